// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and helpers for the RV32M multiply/divide unit
package muldiv_pkg;

   localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   function automatic logic op_a_signed(input muldiv_op_t op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_b_signed(input muldiv_op_t op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - request/response bundle between execute stage and muldiv_ctrl
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             flush;
   logic [WIDTH-1:0] result;
   logic             done;
   logic             busy;
   logic             stall;

   modport master (output start, funct3, op_a, op_b, flush,
                   input  result, done, busy, stall);
   modport slave  (input  start, funct3, op_a, op_b, flush,
                   output result, done, busy, stall);
endinterface

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - one shift-add multiply or restoring-divide iteration
module muldiv_datapath #(parameter int WIDTH = 32) (
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_operand,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shifted;
   logic [WIDTH:0] w_diff;

   // hi:lo is the product (lo starts as multiplier) or remainder:quotient
   always_comb begin
      w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
      w_shifted = {i_hi, i_lo[WIDTH-1]};
      w_diff    = w_shifted - {1'b0, i_operand};
      if (i_is_div) begin
         o_hi = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
         o_lo = {i_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
         o_hi = w_sum[WIDTH:1];
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative RV32M multiply/divide sequencer with pipeline stall
// MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle combinational product
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   muldiv_state_t    r_state, w_next;
   muldiv_op_t       r_op, w_op;
   logic [WIDTH-1:0] r_hi, r_lo, r_opb, r_result;
   logic [CNT_W-1:0] r_count;
   logic             r_neg_res, r_neg_rem, r_done;
   logic             w_accept, w_last, w_stall, w_is_div;
   logic             w_a_neg, w_b_neg, w_div_zero, w_overflow, w_special, w_fast, w_bypass;
   logic [WIDTH-1:0] w_a_mag, w_b_mag, w_step_hi, w_step_lo, w_special_res, w_bypass_res;

   function automatic logic [WIDTH-1:0] select_result(input muldiv_op_t op,
         input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo,
         input logic neg_res, input logic neg_rem);
      logic [2*WIDTH-1:0] prod;
      prod = neg_res ? -{hi, lo} : {hi, lo};
      case (op)
         OP_MUL:                       return prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              return neg_res ? -lo : lo;
         default:                      return neg_rem ? -hi : hi;
      endcase
   endfunction

   assign w_op       = muldiv_op_t'(bus.funct3);
   assign w_accept   = (r_state == IDLE) && bus.start && !bus.flush;
   assign w_last     = (r_count == CNT_W'(WIDTH-1));
   assign w_is_div   = r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   assign w_a_neg    = op_a_signed(w_op) && bus.op_a[WIDTH-1];
   assign w_b_neg    = op_b_signed(w_op) && bus.op_b[WIDTH-1];
   assign w_a_mag    = w_a_neg ? -bus.op_a : bus.op_a;
   assign w_b_mag    = w_b_neg ? -bus.op_b : bus.op_b;

   // Divide-by-zero and INT_MIN / -1 have fixed answers and skip iteration
   assign w_div_zero = bus.funct3[2] && (bus.op_b == '0);
   assign w_overflow = (w_op == OP_DIV || w_op == OP_REM) &&
                       (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.op_b);
   assign w_special  = w_div_zero || w_overflow;
   assign w_special_res = w_div_zero ? (bus.funct3[1] ? bus.op_a : '1)
                                     : (bus.funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] w_fast_prod;
   assign w_fast_prod  = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
   assign w_fast       = !bus.funct3[2];
   assign w_bypass_res = w_fast ? select_result(w_op, w_fast_prod[2*WIDTH-1:WIDTH],
                                                w_fast_prod[WIDTH-1:0], w_a_neg ^ w_b_neg, w_a_neg)
                                : w_special_res;
`else
   assign w_fast       = 1'b0;
   assign w_bypass_res = w_special_res;
`endif
   assign w_bypass = w_special || w_fast;

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .i_is_div  (w_is_div),
      .i_hi      (r_hi),
      .i_lo      (r_lo),
      .i_operand (r_opb),
      .o_hi      (w_step_hi),
      .o_lo      (w_step_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         IDLE: begin
            w_stall = bus.start;
            if (w_accept) w_next = w_bypass ? DONE : CALC;
         end
         CALC: begin
            w_stall = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (bus.flush) begin
         w_next  = IDLE;
         w_stall = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= OP_MUL;
         r_hi      <= '0;
         r_lo      <= '0;
         r_opb     <= '0;
         r_count   <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_result  <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_op      <= w_op;
            r_count   <= '0;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_hi      <= '0;
            r_lo      <= bus.funct3[2] ? w_a_mag : w_b_mag;
            r_opb     <= bus.funct3[2] ? w_b_mag : w_a_mag;
            if (w_bypass) begin
               r_result <= w_bypass_res;
               r_done   <= 1'b1;
            end
         end else if (r_state == CALC && !bus.flush) begin
            r_hi    <= w_step_hi;
            r_lo    <= w_step_lo;
            r_count <= r_count + 1'b1;
            if (w_last) begin
               r_result <= select_result(r_op, w_step_hi, w_step_lo, r_neg_res, r_neg_rem);
               r_done   <= 1'b1;
            end
         end
      end
   end

   assign bus.result = r_result;
   assign bus.done   = r_done;
   assign bus.busy   = (r_state != IDLE);
   assign bus.stall  = w_stall;

endmodule
